// File: rtl/hsv_param_sched.sv
// hsv_param_sched
// Frame-synchronous parameter controller for the HSV adjust stage. Host writes
// land in shadow registers. A commit arms the block, and the live outputs only
// change on the next accepted start-of-frame beat. Optional ramp mode walks the
// sat/val gain/loss bytes toward their targets by RAMP_STEP per frame.
//
// Ports:
//   clk, reset          pixel clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  host writes: 0=ctrl 1=hue 2=sat 3=val 4=commit
//                          (commit: bit0=go, bit1=ramp mode)
//   in_valid/in_ready/in_user  snooped HSV stage input handshake + user field
//   isp_ctrl, isp_hue_offset, isp_sat_gain_loss, isp_val_gain_loss  live values
//   pending             commit armed, waiting for SOF
//   busy                ramp in progress
module hsv_param_sched #(
    parameter int unsigned RAMP_STEP = 8,
    parameter int unsigned SOF_BIT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        in_valid,
    input  logic        in_ready,
    input  logic [7:0]  in_user,
    output logic [15:0] isp_ctrl,
    output logic [15:0] isp_hue_offset,
    output logic [15:0] isp_sat_gain_loss,
    output logic [15:0] isp_val_gain_loss,
    output logic        pending,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ARMED, RAMP} state_t;

    localparam logic [8:0] STEP9   = 9'(RAMP_STEP);
    localparam logic [2:0] SOF_IDX = 3'(SOF_BIT);

    state_t      state, state_nxt;
    logic [15:0] sh_ctrl, sh_hue, sh_sat, sh_val;
    logic [15:0] tgt_sat, tgt_val;
    logic        ramp_mode;

    logic        sof, commit;
    logic        apply, take_direct, take_step, busy_nxt, step_done;
    logic [15:0] sat_t, val_t, sat_step, val_step;
    logic        unused_user;

    assign unused_user = ^in_user;

    assign sof    = in_valid & in_ready & in_user[SOF_IDX];
    assign commit = wr_en & (wr_addr == 3'd4) & wr_data[0];

    // One step of a byte toward its target; a move that would reach or cross
    // the target lands exactly on it, so the byte never wraps.
    function automatic logic [7:0] step_byte(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] diff;
        logic [7:0] res;
        diff = '0;
        res  = tgt;
        if (cur < tgt) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            if (diff > STEP9) res = cur + STEP9[7:0];
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            if (diff > STEP9) res = cur - STEP9[7:0];
        end
        return res;
    endfunction

    // On the arming SOF the new targets come straight from the shadows, so
    // the first ramp step can be taken on that same beat.
    assign sat_t    = (state == ARMED) ? sh_sat : tgt_sat;
    assign val_t    = (state == ARMED) ? sh_val : tgt_val;
    assign sat_step = {step_byte(isp_sat_gain_loss[15:8], sat_t[15:8]),
                       step_byte(isp_sat_gain_loss[7:0],  sat_t[7:0])};
    assign val_step = {step_byte(isp_val_gain_loss[15:8], val_t[15:8]),
                       step_byte(isp_val_gain_loss[7:0],  val_t[7:0])};
    assign step_done = (sat_step == sat_t) && (val_step == val_t);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy_nxt    = busy;
        apply       = 1'b0;
        take_direct = 1'b0;
        take_step   = 1'b0;
        unique case (state)
            IDLE: begin
                if (commit) state_nxt = ARMED;
            end
            ARMED: begin
                if (sof) begin
                    apply = 1'b1;
                    if (ramp_mode) begin
                        take_step = 1'b1;
                        busy_nxt  = !step_done;
                        state_nxt = step_done ? IDLE : RAMP;
                    end else begin
                        take_direct = 1'b1;
                        busy_nxt    = 1'b0;
                        state_nxt   = IDLE;
                    end
                end
            end
            RAMP: begin
                // A re-arm takes precedence; that SOF is not used for a step.
                if (commit) begin
                    state_nxt = ARMED;
                end else if (sof) begin
                    take_step = 1'b1;
                    if (step_done) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_ctrl           <= '0;
            sh_hue            <= '0;
            sh_sat            <= '0;
            sh_val            <= '0;
            tgt_sat           <= '0;
            tgt_val           <= '0;
            ramp_mode         <= 1'b0;
            busy              <= 1'b0;
            isp_ctrl          <= '0;
            isp_hue_offset    <= '0;
            isp_sat_gain_loss <= '0;
            isp_val_gain_loss <= '0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    3'd0:    sh_ctrl <= wr_data;
                    3'd1:    sh_hue  <= wr_data;
                    3'd2:    sh_sat  <= wr_data;
                    3'd3:    sh_val  <= wr_data;
                    default: ;
                endcase
            end
            if (commit) ramp_mode <= wr_data[1];
            if (apply) begin
                isp_ctrl       <= sh_ctrl;
                isp_hue_offset <= sh_hue;
                tgt_sat        <= sh_sat;
                tgt_val        <= sh_val;
            end
            if (take_direct) begin
                isp_sat_gain_loss <= sh_sat;
                isp_val_gain_loss <= sh_val;
            end
            if (take_step) begin
                isp_sat_gain_loss <= sat_step;
                isp_val_gain_loss <= val_step;
            end
            busy <= busy_nxt;
        end
    end

    assign pending = (state == ARMED);

endmodule

// File: tb/tb_hsv_param_sched.sv
// tb_hsv_param_sched
// Directed bench for hsv_param_sched. A frame-level reference model tracks
// shadows, targets and live bytes as integers and is compared against the DUT
// every cycle; literal expectations pin the model at the key points.
module tb_hsv_param_sched;

    localparam int STEP = 8;

    logic        clk, reset, wr_en, in_valid, in_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  in_user;
    logic [15:0] isp_ctrl, isp_hue_offset, isp_sat_gain_loss, isp_val_gain_loss;
    logic        pending, busy;

    int checks = 0;
    int errors = 0;

    hsv_param_sched #(.RAMP_STEP(STEP), .SOF_BIT(0)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_user(in_user),
        .isp_ctrl(isp_ctrl), .isp_hue_offset(isp_hue_offset),
        .isp_sat_gain_loss(isp_sat_gain_loss), .isp_val_gain_loss(isp_val_gain_loss),
        .pending(pending), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_ctrl, m_hue, sh_ctrl, sh_hue, sh_sat, sh_val;
    int live[4];   // sat gain, sat loss, val gain, val loss
    int tgt[4];
    bit m_pending, m_busy, m_ramp, m_commit, m_ev;

    function automatic int mv(int c, int t);
        if (c < t) return (c + STEP >= t) ? t : c + STEP;
        if (c > t) return (c - STEP <= t) ? t : c - STEP;
        return t;
    endfunction

    task automatic model_step();
        bit all_eq;
        all_eq = 1;
        for (int i = 0; i < 4; i++) begin
            live[i] = mv(live[i], tgt[i]);
            if (live[i] != tgt[i]) all_eq = 0;
        end
        m_busy = !all_eq;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl = 0; m_hue = 0; sh_ctrl = 0; sh_hue = 0; sh_sat = 0; sh_val = 0;
            for (int i = 0; i < 4; i++) begin live[i] = 0; tgt[i] = 0; end
            m_pending = 0; m_busy = 0; m_ramp = 0;
        end else begin
            m_commit = wr_en && wr_addr == 3'd4 && wr_data[0];
            m_ev     = in_valid && in_ready && in_user[0];
            if (m_pending && m_ev) begin
                m_ctrl = sh_ctrl; m_hue = sh_hue;
                tgt[0] = sh_sat / 256; tgt[1] = sh_sat % 256;
                tgt[2] = sh_val / 256; tgt[3] = sh_val % 256;
                m_pending = 0;
                if (m_ramp) model_step();
                else begin
                    for (int i = 0; i < 4; i++) live[i] = tgt[i];
                    m_busy = 0;
                end
            end else if (m_commit) begin
                m_pending = 1;
            end else if (m_busy && m_ev) begin
                model_step();
            end
            if (m_commit) m_ramp = wr_data[1];
            if (wr_en) begin
                if (wr_addr == 3'd0) sh_ctrl = int'(wr_data);
                if (wr_addr == 3'd1) sh_hue  = int'(wr_data);
                if (wr_addr == 3'd2) sh_sat  = int'(wr_data);
                if (wr_addr == 3'd3) sh_val  = int'(wr_data);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cmp("ctrl",    isp_ctrl,          16'(m_ctrl));
        cmp("hue",     isp_hue_offset,    16'(m_hue));
        cmp("sat",     isp_sat_gain_loss, 16'(live[0] * 256 + live[1]));
        cmp("val",     isp_val_gain_loss, 16'(live[2] * 256 + live[3]));
        cmp("pending", {15'd0, pending},  {15'd0, m_pending});
        cmp("busy",    {15'd0, busy},     {15'd0, m_busy});
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic sof(input logic rdy);
        in_valid = 1; in_ready = rdy; in_user = 8'h01;
        @(negedge clk);
        in_valid = 0; in_ready = 1; in_user = '0;
    endtask

    task automatic wr_sof(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        in_valid = 1; in_ready = 1; in_user = 8'h01;
        @(negedge clk);
        wr_en = 0; wr_addr = '0; wr_data = '0;
        in_valid = 0; in_user = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
        in_valid = 0; in_ready = 1; in_user = '0;
        repeat (2) @(negedge clk);
        cmp("rst_ctrl", isp_ctrl, 16'h0000);
        cmp("rst_sat",  isp_sat_gain_loss, 16'h0000);
        cmp("rst_pend", {15'd0, pending}, 16'h0000);
        reset = 0;
        @(negedge clk);

        // no writes, three SOFs: nothing moves
        repeat (3) begin sof(1); @(negedge clk); end
        cmp("idle_ctrl", isp_ctrl, 16'h0000);
        cmp("idle_busy", {15'd0, busy}, 16'h0000);

        // direct apply, with an unaccepted SOF in between
        wr(3'd0, 16'h3C01); wr(3'd1, 16'h0020); wr(3'd2, 16'h4010);
        wr(3'd4, 16'h0001);
        cmp("armed_pend", {15'd0, pending}, 16'h0001);
        sof(0);
        cmp("noready_ctrl", isp_ctrl, 16'h0000);
        repeat (2) @(negedge clk);
        sof(1);
        cmp("apply_ctrl", isp_ctrl, 16'h3C01);
        cmp("apply_hue",  isp_hue_offset, 16'h0020);
        cmp("apply_sat",  isp_sat_gain_loss, 16'h4010);
        cmp("apply_pend", {15'd0, pending}, 16'h0000);

        // increasing ramp from 0x0000 to 0x1805
        wr(3'd2, 16'h0000); wr(3'd4, 16'h0001); sof(1);
        cmp("zero_sat", isp_sat_gain_loss, 16'h0000);
        wr(3'd2, 16'h1805); wr(3'd4, 16'h0003); @(negedge clk);
        sof(1);
        cmp("ramp1_sat",  isp_sat_gain_loss, 16'h0805);
        cmp("ramp1_busy", {15'd0, busy}, 16'h0001);
        @(negedge clk); sof(1);
        cmp("ramp2_sat",  isp_sat_gain_loss, 16'h1005);
        sof(1);
        cmp("ramp3_sat",  isp_sat_gain_loss, 16'h1805);
        cmp("ramp3_busy", {15'd0, busy}, 16'h0000);

        // decreasing ramp 0xFF00 -> 0xF300 with clamp
        wr(3'd3, 16'hFF00); wr(3'd4, 16'h0001); sof(1);
        cmp("val_ff", isp_val_gain_loss, 16'hFF00);
        wr(3'd3, 16'hF300); wr(3'd4, 16'h0003); sof(1);
        cmp("dec1_val", isp_val_gain_loss, 16'hF700);
        sof(1);
        cmp("dec2_val",  isp_val_gain_loss, 16'hF300);
        cmp("dec2_busy", {15'd0, busy}, 16'h0000);

        // commit and SOF together while idle: that SOF is not used
        wr(3'd1, 16'h0055);
        wr_sof(3'd4, 16'h0001);
        cmp("same_hue",  isp_hue_offset, 16'h0020);
        cmp("same_pend", {15'd0, pending}, 16'h0001);
        sof(1);
        cmp("next_hue", isp_hue_offset, 16'h0055);

        // shadow write together with SOF: apply sees the old shadow
        wr(3'd4, 16'h0001);
        wr_sof(3'd1, 16'h0077);
        cmp("oldsh_hue", isp_hue_offset, 16'h0055);
        wr(3'd4, 16'h0001); sof(1);
        cmp("newsh_hue", isp_hue_offset, 16'h0077);

        // reset in the middle of a ramp
        wr(3'd2, 16'h4040); wr(3'd4, 16'h0003); sof(1);
        cmp("mid_sat", isp_sat_gain_loss, 16'h200D);
        #2 reset = 1;
        #1;
        cmp("arst_sat",  isp_sat_gain_loss, 16'h0000);
        cmp("arst_val",  isp_val_gain_loss, 16'h0000);
        cmp("arst_busy", {15'd0, busy}, 16'h0000);
        @(negedge clk);
        reset = 0;
        wr(3'd2, 16'h0010); wr(3'd4, 16'h0003); sof(1);
        cmp("post_sat", isp_sat_gain_loss, 16'h0008);
        cmp("post_busy", {15'd0, busy}, 16'h0001);
        sof(1);
        cmp("post2_sat", isp_sat_gain_loss, 16'h0010);

        // re-arm during a ramp, finishing with a direct load
        wr(3'd2, 16'h3000); wr(3'd4, 16'h0003); sof(1);
        cmp("rearm_sat", isp_sat_gain_loss, 16'h0808);
        wr(3'd2, 16'h0000); wr(3'd4, 16'h0001);
        cmp("rearm_pend", {15'd0, pending}, 16'h0001);
        sof(1);
        cmp("rearm_done", isp_sat_gain_loss, 16'h0000);
        cmp("rearm_busy", {15'd0, busy}, 16'h0000);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
